// File: rtl/pipe_addsub.sv
// pipe_addsub: chunked, pipelined adder/subtractor with valid/ready flow control.
// Stage k adds bits [k*CW +: CW] using the carry registered by stage k-1.
// Each stage register carries the operands, the partial result and the
// carry, so every stage holds one complete in-flight operation.
module pipe_addsub #(
  parameter int SIZE   = 32,
  parameter int STAGES = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  input  logic            sub,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SIZE-1:0] outA,
  output logic            cout,
  output logic            ovf
);

  localparam int CW   = SIZE / STAGES;
  localparam int LAST = STAGES - 1;

  // One chunk of the ripple: CW-bit sum plus carry out in the top bit.
  function automatic logic [CW:0] add_chunk(input logic [CW-1:0] x,
                                            input logic [CW-1:0] y,
                                            input logic          c);
    return {1'b0, x} + {1'b0, y} + {{CW{1'b0}}, c};
  endfunction

  logic [STAGES-1:0] r_vld;
  logic [STAGES-1:0] r_c;
  logic [SIZE-1:0]   r_a   [STAGES];
  logic [SIZE-1:0]   r_bx  [STAGES];
  logic [SIZE-1:0]   r_res [STAGES];
  logic              r_ovf;

  logic [STAGES-1:0] w_en;
  logic [STAGES-1:0] w_vld_src;
  logic [STAGES-1:0] w_nxt_c;
  logic [SIZE-1:0]   w_src_a   [STAGES];
  logic [SIZE-1:0]   w_src_bx  [STAGES];
  logic [SIZE-1:0]   w_nxt_res [STAGES];
  logic              w_nxt_ovf;
  logic              w_stall;
  logic              w_accept;

  // Only a result waiting on the consumer stalls the front; reset hides it.
  assign out_valid = rst_n & r_vld[LAST];
  assign w_stall   = out_valid & ~out_ready;
  assign in_ready  = ~w_stall;
  assign w_accept  = in_valid & in_ready & ~flush;

  assign outA = r_res[LAST];
  assign cout = r_c[LAST];
  assign ovf  = r_ovf;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam logic [SIZE-1:0] MASK = SIZE'({CW{1'b1}}) << (k * CW);

    logic [SIZE-1:0] w_res;
    logic            w_c;
    logic [CW:0]     w_sum;

    if (k == 0) begin : g_head
      // Subtraction is a + ~b + 1: invert b here and inject sub as carry-in.
      assign w_src_a[k]   = a;
      assign w_src_bx[k]  = b ^ {SIZE{sub}};
      assign w_res        = '0;
      assign w_c          = sub;
      assign w_vld_src[k] = w_accept;
    end else begin : g_body
      assign w_src_a[k]   = r_a[k-1];
      assign w_src_bx[k]  = r_bx[k-1];
      assign w_res        = r_res[k-1];
      assign w_c          = r_c[k-1];
      assign w_vld_src[k] = r_vld[k-1];
    end

    assign w_sum        = add_chunk(w_src_a[k][k*CW +: CW], w_src_bx[k][k*CW +: CW], w_c);
    assign w_nxt_res[k] = (w_res & ~MASK) | (SIZE'(w_sum[CW-1:0]) << (k * CW));
    assign w_nxt_c[k]   = w_sum[CW];

    // A stage moves when the consumer takes data or any later stage is empty,
    // which lets bubbles collapse behind a stalled output.
    assign w_en[k] = out_ready | ~(&r_vld[LAST:k]);

    if (k == LAST) begin : g_tail
      assign w_nxt_ovf = (w_src_a[k][SIZE-1] == w_src_bx[k][SIZE-1]) &&
                         (w_nxt_res[k][SIZE-1] != w_src_a[k][SIZE-1]);
    end
  end

  // Stage valid bits: reset and flush empty the pipe, otherwise shift on enable.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      r_vld <= '0;
    end else begin
      r_vld <= (r_vld & ~w_en) | (w_vld_src & w_en);
    end
  end

  // Stage data: operands, partial sums and carries advance with their valids.
  always_ff @(posedge clk) begin
    for (int k = 0; k < STAGES; k++) begin
      if (w_en[k]) begin
        r_res[k] <= w_nxt_res[k];
        r_c[k]   <= w_nxt_c[k];
        if (k < LAST) begin
          r_a[k]  <= w_src_a[k];
          r_bx[k] <= w_src_bx[k];
        end
      end
    end
    if (w_en[LAST]) begin
      r_ovf <= w_nxt_ovf;
    end
    if (!rst_n) begin
      r_res[LAST] <= '0;
      r_c[LAST]   <= 1'b0;
      r_ovf       <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pipe_addsub.sv
// tb_pipe_addsub: self-checking bench for pipe_addsub (SIZE=32, STAGES=4).
module tb_pipe_addsub;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        sub;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] outA;
  logic        cout;
  logic        ovf;

  int checks   = 0;
  int failures = 0;

  pipe_addsub #(.SIZE(32), .STAGES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .outA(outA), .cout(cout), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer arithmetic, returns {ovf, cout, result}.
  function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y, input logic s);
    logic [32:0] u;
    longint      sr;
    logic        v;
    if (!s) u = {1'b0, x} + {1'b0, y};
    else    u = {(x >= y), x - y};
    if (!s) sr = longint'($signed(x)) + longint'($signed(y));
    else    sr = longint'($signed(x)) - longint'($signed(y));
    v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    return {v, u};
  endfunction

  function automatic logic [31:0] corner(input int idx);
    case (idx)
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'hFFFF_FFFF;
      default: return 32'h0000_00FF;
    endcase
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; a = 32'h1; b = 32'h1; sub = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || outA !== 32'h0 || cout !== 1'b0 || ovf !== 1'b0)
      begin failures++; $display("FAIL reset_state: got v=%b rdy=%b out=%h c=%b o=%b want v=0 rdy=1 out=0 c=0 o=0",
                                 out_valid, in_ready, outA, cout, ovf); end
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_single_op(input string nm, input logic [31:0] xa, input logic [31:0] xb,
                                input logic xs, input logic [31:0] eo, input logic ec, input logic ev);
    a = xa; b = xb; sub = xs; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL %s_accept: got in_ready=%b want 1", nm, in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0; a = $urandom; b = $urandom; sub = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      #1;
      if (c < 4) begin
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL %s_early: got out_valid=1 at cycle %0d want 0", nm, c); end
        @(posedge clk); #1;
      end else begin
        checks++;
        if (out_valid !== 1'b1 || outA !== eo || cout !== ec || ovf !== ev)
          begin failures++; $display("FAIL %s: got v=%b out=%h c=%b o=%b want v=1 out=%h c=%b o=%b",
                                     nm, out_valid, outA, cout, ovf, eo, ec, ev); end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    test_single_op("add_carry_chunks", 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
    test_single_op("sub_borrow",       32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    test_single_op("add_overflow",     32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    test_single_op("add_wrap",         32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    test_single_op("sub_overflow",     32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_q[$];
    logic [33:0] held;
    int          nxt = 1;
    int          got = 0;
    int          stall_left = 0;
    bit          was_stalled = 1'b0;
    for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
      in_valid  = (nxt <= 8);
      a = 32'(nxt); b = 32'(nxt); sub = 1'b0;
      out_ready = (stall_left == 0);
      #1;
      if (was_stalled) begin
        checks++;
        if (out_valid !== 1'b1 || {ovf, cout, outA} !== held)
          begin failures++; $display("FAIL b2b_hold: got v=%b val=%h want v=1 val=%h", out_valid, {ovf, cout, outA}, held); end
      end
      checks++;
      if (in_ready !== out_ready)
        begin failures++; $display("FAIL b2b_in_ready: got %b want %b (cycle %0d)", in_ready, out_ready, cyc); end
      if (in_valid && in_ready) begin exp_q.push_back(32'(2 * nxt)); nxt++; end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin failures++; $display("FAIL b2b_extra: got out=%h want no result", outA); end
        else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          if (outA !== e) begin failures++; $display("FAIL b2b_order: got %h want %h", outA, e); end
        end
        got++;
        if (got == 1) stall_left = 3;
      end else if (!out_ready) begin
        stall_left--;
      end
      was_stalled = out_valid && !out_ready;
      held = {ovf, cout, outA};
      @(posedge clk); #1;
    end
    checks++;
    if (got != 8) begin failures++; $display("FAIL b2b_count: got %0d results want 8", got); end
    in_valid = 1'b0; out_ready = 1'b1;
  endtask

  task automatic test_flush();
    bit found;
    for (int c = 0; c <= 8; c++) begin
      in_valid = (c <= 4); flush = (c == 3); out_ready = 1'b1; sub = 1'b0;
      a = (c == 4) ? 32'h1234_5678 : 32'(32'h1000 + c);
      b = (c == 4) ? 32'h1111_1111 : 32'(c);
      #1;
      if (c >= 4 && c < 8) begin
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_drop: got out_valid=1 out=%h at cycle %0d want 0", outA, c); end
      end
      if (c == 8) begin
        checks++;
        if (out_valid !== 1'b1 || outA !== 32'h2345_6789 || cout !== 1'b0 || ovf !== 1'b0)
          begin failures++; $display("FAIL flush_resume: got v=%b out=%h c=%b o=%b want v=1 out=23456789 c=0 o=0",
                                     out_valid, outA, cout, ovf); end
      end
      @(posedge clk); #1;
    end
    flush = 1'b0; in_valid = 1'b0;
    // Flush while the output is stalled.
    a = 32'd5; b = 32'd6; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      #1;
      if (out_valid === 1'b1) found = 1'b1;
      else begin @(posedge clk); #1; end
    end
    checks++;
    if (!found) begin failures++; $display("FAIL flush_stall_wait: got no out_valid within 10 cycles want result"); end
    else if (outA !== 32'd11) begin failures++; $display("FAIL flush_stall_value: got %h want 0000000b", outA); end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin failures++; $display("FAIL flush_over_stall: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready); end
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midstream();
    for (int c = 0; c <= 8; c++) begin
      rst_n    = (c != 3);
      in_valid = (c < 3) || (c == 4);
      a = (c == 4) ? 32'hA5A5_0000 : 32'(256 * (c + 1));
      b = (c == 4) ? 32'h0000_5A5A : 32'h0000_0001;
      sub = 1'b0; out_ready = 1'b1;
      #1;
      if (c == 3) begin
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
          begin failures++; $display("FAIL rst_mid_during: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready); end
      end
      if (c == 4) begin
        checks++;
        if (out_valid !== 1'b0 || outA !== 32'h0 || cout !== 1'b0 || ovf !== 1'b0)
          begin failures++; $display("FAIL rst_mid_clear: got v=%b out=%h c=%b o=%b want v=0 out=0 c=0 o=0",
                                     out_valid, outA, cout, ovf); end
      end
      if (c > 4 && c < 8) begin
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_drop: got out_valid=1 out=%h at cycle %0d want 0", outA, c); end
      end
      if (c == 8) begin
        checks++;
        if (out_valid !== 1'b1 || outA !== 32'hA5A5_5A5A || cout !== 1'b0 || ovf !== 1'b0)
          begin failures++; $display("FAIL rst_mid_resume: got v=%b out=%h c=%b o=%b want v=1 out=a5a55a5a c=0 o=0",
                                     out_valid, outA, cout, ovf); end
      end
      @(posedge clk); #1;
    end
    rst_n = 1'b1; in_valid = 1'b0;
  endtask

  task automatic test_random();
    logic [33:0] q[$];
    logic [33:0] obs;
    logic [33:0] held;
    logic [33:0] e;
    bit          was_stalled = 1'b0;
    for (int cyc = 0; cyc < 420; cyc++) begin
      if (cyc < 400) begin
        in_valid  = ($urandom_range(0, 9) < 7);
        out_ready = ($urandom_range(0, 9) < 7);
      end else begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
      a   = ($urandom_range(0, 3) == 0) ? corner($urandom_range(0, 5)) : $urandom;
      b   = ($urandom_range(0, 3) == 0) ? corner($urandom_range(0, 5)) : $urandom;
      sub = $urandom_range(0, 1);
      #1;
      obs = {ovf, cout, outA};
      if (was_stalled) begin
        checks++;
        if (out_valid !== 1'b1 || obs !== held)
          begin failures++; $display("FAIL rand_hold: got v=%b val=%h want v=1 val=%h", out_valid, obs, held); end
      end
      if (in_valid && in_ready) q.push_back(model(a, b, sub));
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin failures++; $display("FAIL rand_extra: got val=%h want no result", obs); end
        else begin
          e = q.pop_front();
          if (obs !== e) begin failures++; $display("FAIL rand_result: got {ovf,cout,out}=%h want %h", obs, e); end
        end
      end
      was_stalled = out_valid && !out_ready;
      held = obs;
      @(posedge clk); #1;
    end
    checks++;
    if (q.size() != 0) begin failures++; $display("FAIL rand_drain: got %0d results outstanding want 0", q.size()); end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; flush = 1'b0; out_ready = 1'b1;
    test_reset();
    test_directed();
    test_back_to_back();
    test_flush();
    test_reset_midstream();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000 time units want finish");
    $fatal(1);
  end

endmodule

// File: doc/pipe_addsub.md
PIPE_ADDSUB -- requirements
Module: pipe_addsub

Interface
REQ-001 The block SHALL have parameter SIZE, default 32, giving the operand and result width in bits.
REQ-002 The block SHALL have parameter STAGES, default 4, giving the pipeline depth; legal values are 1, 2, 4 and 8, and SIZE SHALL be divisible by STAGES.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: synchronous active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the operand set is valid this cycle.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts operands this cycle.
REQ-007 The block SHALL have port a, input, SIZE bits: first operand.
REQ-008 The block SHALL have port b, input, SIZE bits: second operand.
REQ-009 The block SHALL have port sub, input, 1 bit: 0 = a+b, 1 = a-b.
REQ-010 The block SHALL have port flush, input, 1 bit: discard all in-flight operations.
REQ-011 The block SHALL have port out_valid, output, 1 bit: the result is valid this cycle.
REQ-012 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result this cycle.
REQ-013 The block SHALL have port outA, output, SIZE bits: the result, modulo 2^SIZE.
REQ-014 The block SHALL have port cout, output, 1 bit: the carry out of bit SIZE-1.
REQ-015 The block SHALL have port ovf, output, 1 bit: the two's-complement signed overflow flag.

Function
REQ-016 Transfer rule: an operand set SHALL be accepted when in_valid && in_ready, and a result SHALL be consumed when out_valid && out_ready.
REQ-017 Arithmetic: the block SHALL compute a + (b XOR {SIZE{sub}}) + sub, so subtraction is a + ~b + 1.
REQ-018 Chunking: the operation SHALL be split into STAGES chunks of CW = SIZE/STAGES bits, where stage k adds chunk k (bits k*CW .. k*CW+CW-1) using the carry registered from stage k-1, and stage 0 uses carry-in = sub.
REQ-019 Skew: the unprocessed upper operand chunks and the completed lower result chunks SHALL travel in pipeline registers alongside each stage, so every stage holds one complete in-flight operation.
REQ-020 Latency: a result SHALL be presented on out_valid exactly STAGES cycles after acceptance, provided no stall occurs.
REQ-021 Throughput: the block SHALL accept one operation per cycle while out_ready=1.
REQ-022 cout SHALL be the carry out of the final chunk; for subtraction, cout=1 SHALL mean no borrow (a >= b unsigned).
REQ-023 ovf SHALL equal 1 iff the sign bits of a and (b XOR {SIZE{sub}}) are equal and the sign bit of outA differs from them.
REQ-024 Stall: when out_valid && !out_ready, the entire pipeline SHALL hold its contents, in_ready SHALL be 0, and outA, cout and ovf SHALL remain stable.
REQ-025 Bubbles: the stall condition of REQ-024 is the only condition that drives in_ready low, so in_ready SHALL be 1 even when the pipeline is full, provided out_ready=1.
REQ-026 Bubbles SHALL be compressed: an invalid stage SHALL advance, or be filled, even while a later stage is valid and stalled.
REQ-027 Flush: flush=1 SHALL clear all stage valid bits on the next edge and SHALL NOT accept that cycle's input, regardless of in_valid.
REQ-028 Flush priority: flush SHALL take priority over a stall and over a simultaneous transfer.
REQ-029 Ordering: results SHALL exit in acceptance order, with no duplicates and no drops except those caused by flush.
REQ-030 STAGES=1: the block SHALL degenerate to a single registered adder with latency 1.

Reset
REQ-031 When rst_n=0 at a rising edge, all stage valid bits SHALL clear and outA, cout and ovf SHALL become 0.
REQ-032 During reset, out_valid SHALL be 0 and in_ready SHALL be 1.
REQ-033 Reset asserted mid-operation SHALL discard every in-flight operation.
REQ-034 The first operation SHALL be accepted on the first edge with rst_n=1.
REQ-035 rst_n SHALL take priority over flush and over all transfers.

Verification (SIZE=32, STAGES=4)
REQ-036 Add with carry across chunks: a=0x000000FF, b=0x00000001, sub=0 accepted at cycle 0 -> out_valid at cycle 4, outA=0x00000100, cout=0, ovf=0.
REQ-037 Subtract with borrow: a=0x00000000, b=0x00000001, sub=1 -> outA=0xFFFFFFFF, cout=0, ovf=0.
REQ-038 Overflow and wrap: 0x7FFFFFFF+0x00000001 -> outA=0x80000000, ovf=1, cout=0; 0xFFFFFFFF+0x00000001 -> outA=0x00000000, cout=1, ovf=0.
REQ-039 Back-to-back with stall: issue 8 consecutive adds (i+i for i=1..8) and hold out_ready=0 for 3 cycles after the first result -> results 2,4,...,16 appear in order, each held stable during the stall, with in_ready=0 throughout the stall.
REQ-040 Flush: issue 3 operations, assert flush for 1 cycle before any result appears -> no out_valid; an add issued the next cycle returns correctly after 4 cycles.
REQ-041 Reset mid-stream: assert rst_n=0 for 1 cycle with 3 operations in flight -> out_valid=0 and outA=0; the pipeline resumes normally afterwards.
